// File: rtl/branch_control_unit.sv
// Hardwired control sequencer for the Mini SRC datapath: instruction fetch plus
// the branch / jr / nop / halt class, emitting one-hot T-step control strobes.
module branch_control_unit #(
   parameter logic [4:0] OP_BR   = 5'b10010,
   parameter logic [4:0] OP_JR   = 5'b10011,
   parameter logic [4:0] OP_NOP  = 5'b11010,
   parameter logic [4:0] OP_HALT = 5'b11011,
   parameter logic [4:0] ALU_ADD = 5'b00011
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        start,
   input  logic        stop,
   input  logic        mem_ready,
   input  logic [31:0] IR_Data,
   input  logic        CON_ff,
   output logic        PC_in,
   output logic        IR_in,
   output logic        Y_in,
   output logic        Z_in,
   output logic        MAR_in,
   output logic        MDR_in,
   output logic        IncPC,
   output logic        PC_out,
   output logic        Zlow_out,
   output logic        MDR_out,
   output logic        C_out,
   output logic        Read,
   output logic        Gra,
   output logic        Grb,
   output logic        Rout,
   output logic        CON_in,
   output logic [4:0]  alu_instruction_bits,
   output logic        run,
   output logic        illegal
);

   typedef enum logic [3:0] {
      S_IDLE, S_T0, S_T1, S_T2, S_T3, S_B4, S_B5, S_B6, S_HALT
   } state_t;

   state_t     state, state_nxt;
   logic       pc_done;
   logic       illegal_set;
   logic [4:0] opcode;
   logic       unused_ir_bits;

   assign opcode         = IR_Data[31:27];
   assign unused_ir_bits = ^IR_Data[26:0];

   // pc_done remembers that PC was already advanced during this T1 memory wait
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state   <= S_IDLE;
         pc_done <= 1'b0;
         illegal <= 1'b0;
      end else begin
         state   <= state_nxt;
         pc_done <= (state == S_T1);
         if (illegal_set) illegal <= 1'b1;
      end
   end

   always_comb begin
      state_nxt            = state;
      illegal_set          = 1'b0;
      PC_in                = 1'b0;
      IR_in                = 1'b0;
      Y_in                 = 1'b0;
      Z_in                 = 1'b0;
      MAR_in               = 1'b0;
      MDR_in               = 1'b0;
      IncPC                = 1'b0;
      PC_out               = 1'b0;
      Zlow_out             = 1'b0;
      MDR_out              = 1'b0;
      C_out                = 1'b0;
      Read                 = 1'b0;
      Gra                  = 1'b0;
      Grb                  = 1'b0;
      Rout                 = 1'b0;
      CON_in               = 1'b0;
      alu_instruction_bits = 5'd0;
      run                  = 1'b0;
      case (state)
         S_IDLE, S_HALT: begin
            if (start && !stop) state_nxt = S_T0;
         end
         S_T0: begin
            run       = 1'b1;
            PC_out    = 1'b1;
            MAR_in    = 1'b1;
            IncPC     = 1'b1;
            Z_in      = 1'b1;
            state_nxt = S_T1;
         end
         S_T1: begin
            run      = 1'b1;
            Zlow_out = 1'b1;
            PC_in    = !pc_done;
            Read     = 1'b1;
            MDR_in   = 1'b1;
            if (mem_ready) state_nxt = S_T2;
         end
         S_T2: begin
            run       = 1'b1;
            MDR_out   = 1'b1;
            IR_in     = 1'b1;
            state_nxt = S_T3;
         end
         S_T3: begin
            run = 1'b1;
            // jr and nop end here, so stop is sampled at this boundary
            if (opcode == OP_BR) begin
               Grb       = 1'b1;
               Rout      = 1'b1;
               CON_in    = 1'b1;
               state_nxt = S_B4;
            end else if (opcode == OP_JR) begin
               Gra       = 1'b1;
               Rout      = 1'b1;
               PC_in     = 1'b1;
               state_nxt = stop ? S_HALT : S_T0;
            end else if (opcode == OP_NOP) begin
               state_nxt = stop ? S_HALT : S_T0;
            end else if (opcode == OP_HALT) begin
               state_nxt = S_HALT;
            end else begin
               illegal_set = 1'b1;
               state_nxt   = S_HALT;
            end
         end
         S_B4: begin
            run       = 1'b1;
            PC_out    = 1'b1;
            Y_in      = 1'b1;
            state_nxt = S_B5;
         end
         S_B5: begin
            run                  = 1'b1;
            C_out                = 1'b1;
            alu_instruction_bits = ALU_ADD;
            Z_in                 = 1'b1;
            state_nxt            = S_B6;
         end
         S_B6: begin
            run       = 1'b1;
            Zlow_out  = CON_ff;
            PC_in     = CON_ff;
            state_nxt = stop ? S_HALT : S_T0;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_branch_control_unit.sv
// Bench for branch_control_unit: directed scenarios plus randomized instruction
// streams, each expanded into its expected per-cycle strobe trace.
module tb_branch_control_unit;

   logic        clk = 1'b0;
   logic        clr, start, stop, mem_ready, CON_ff;
   logic [31:0] IR_Data;
   logic        PC_in, IR_in, Y_in, Z_in, MAR_in, MDR_in, IncPC, PC_out;
   logic        Zlow_out, MDR_out, C_out, Read, Gra, Grb, Rout, CON_in;
   logic [4:0]  alu_instruction_bits;
   logic        run, illegal;

   int errors = 0;
   int checks = 0;
   bit ill_m  = 1'b0;

   localparam logic [4:0] OP_BR = 5'b10010, OP_JR = 5'b10011;
   localparam logic [4:0] OP_NOP = 5'b11010, OP_HALT = 5'b11011;

   localparam logic [22:0] M_RUN  = 23'd1 << 1,  M_ADD  = 23'd3 << 2;
   localparam logic [22:0] M_CONI = 23'd1 << 7,  M_ROUT = 23'd1 << 8;
   localparam logic [22:0] M_GRB  = 23'd1 << 9,  M_GRA  = 23'd1 << 10;
   localparam logic [22:0] M_READ = 23'd1 << 11, M_COUT = 23'd1 << 12;
   localparam logic [22:0] M_MDRO = 23'd1 << 13, M_ZLO  = 23'd1 << 14;
   localparam logic [22:0] M_PCO  = 23'd1 << 15, M_INC  = 23'd1 << 16;
   localparam logic [22:0] M_MDRI = 23'd1 << 17, M_MARI = 23'd1 << 18;
   localparam logic [22:0] M_ZI   = 23'd1 << 19, M_YI   = 23'd1 << 20;
   localparam logic [22:0] M_IRI  = 23'd1 << 21, M_PCI  = 23'd1 << 22;

   localparam logic [22:0] X_IDLE = 23'd0;
   localparam logic [22:0] X_NONE = M_RUN;
   localparam logic [22:0] X_T0   = M_RUN | M_PCO | M_MARI | M_INC | M_ZI;
   localparam logic [22:0] X_T1F  = M_RUN | M_ZLO | M_PCI | M_READ | M_MDRI;
   localparam logic [22:0] X_T1W  = M_RUN | M_ZLO | M_READ | M_MDRI;
   localparam logic [22:0] X_T2   = M_RUN | M_MDRO | M_IRI;
   localparam logic [22:0] X_BR3  = M_RUN | M_GRB | M_ROUT | M_CONI;
   localparam logic [22:0] X_JR3  = M_RUN | M_GRA | M_ROUT | M_PCI;
   localparam logic [22:0] X_B4   = M_RUN | M_PCO | M_YI;
   localparam logic [22:0] X_B5   = M_RUN | M_COUT | M_ADD | M_ZI;
   localparam logic [22:0] X_B6T  = M_RUN | M_ZLO | M_PCI;

   logic [22:0] obs;
   assign obs = {PC_in, IR_in, Y_in, Z_in, MAR_in, MDR_in, IncPC, PC_out,
                 Zlow_out, MDR_out, C_out, Read, Gra, Grb, Rout, CON_in,
                 alu_instruction_bits, run, illegal};

   branch_control_unit dut (
      .clk(clk), .clr(clr), .start(start), .stop(stop), .mem_ready(mem_ready),
      .IR_Data(IR_Data), .CON_ff(CON_ff),
      .PC_in(PC_in), .IR_in(IR_in), .Y_in(Y_in), .Z_in(Z_in), .MAR_in(MAR_in),
      .MDR_in(MDR_in), .IncPC(IncPC), .PC_out(PC_out), .Zlow_out(Zlow_out),
      .MDR_out(MDR_out), .C_out(C_out), .Read(Read), .Gra(Gra), .Grb(Grb),
      .Rout(Rout), .CON_in(CON_in), .alu_instruction_bits(alu_instruction_bits),
      .run(run), .illegal(illegal)
   );

   always #5 clk = ~clk;

   // Minimal datapath reacting to the strobes, used to confirm resulting PC values
   logic [31:0] pc, z, y, bus;
   logic        dp_clr = 1'b0;

   function automatic logic [31:0] rf(input logic [3:0] idx);
      return 32'h100 + 32'(idx) * 32'd16;
   endfunction

   always_comb begin
      bus = 32'd0;
      if (PC_out)             bus = pc;
      else if (Zlow_out)      bus = z;
      else if (C_out)         bus = {{13{IR_Data[18]}}, IR_Data[18:0]};
      else if (Rout && Gra)   bus = rf(IR_Data[26:23]);
      else if (Rout && Grb)   bus = rf(IR_Data[22:19]);
   end

   always @(posedge clk) begin
      if (dp_clr)     pc <= 32'd0;
      else if (PC_in) pc <= bus;
      if (Y_in) y <= bus;
      if (Z_in) z <= IncPC ? bus + 32'd1 : (alu_instruction_bits == 5'b00011 ? y + bus : bus);
   end

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic cyc(input logic st, input logic sp, input logic mr, input logic con,
                      input logic [31:0] ir, input logic [22:0] exp_v, input string tag);
      logic [22:0] e;
      @(negedge clk);
      start = st; stop = sp; mem_ready = mr; CON_ff = con; IR_Data = ir;
      #1;
      e = exp_v | {22'd0, ill_m};
      checks++;
      assert (obs === e) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, want);
      end
   endtask

   task automatic resume(input int n);
      for (int k = 0; k < n; k++) begin
         logic s, p;
         s = rb(); p = rb();
         if (s && !p) p = 1'b1;
         cyc(s, p, rb(), rb(), 32'd0, X_IDLE, "idle_hold");
      end
      cyc(1'b1, 1'b0, rb(), rb(), 32'd0, X_IDLE, "idle_go");
   endtask

   task automatic pc_reset();
      dp_clr = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, X_IDLE, "idle_pcclr");
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, X_IDLE, "idle_pcclr");
      dp_clr = 1'b0;
   endtask

   // Expected trace of one instruction starting in T0; halted reports whether it ends in HALT
   task automatic do_instr(input logic [31:0] ir, input int waits, input logic con,
                           input logic stop_b, input bit abort_b5, output bit halted);
      logic [4:0]  op;
      logic [22:0] x3;
      op = ir[31:27];
      halted = 1'b0;
      cyc(rb(), rb(), rb(), rb(), ir, X_T0, "t0");
      for (int w = 0; w <= waits; w++)
         cyc(rb(), rb(), (w == waits), rb(), ir, (w == 0) ? X_T1F : X_T1W, "t1");
      cyc(rb(), rb(), rb(), rb(), ir, X_T2, "t2");
      x3 = (op == OP_BR) ? X_BR3 : (op == OP_JR) ? X_JR3 : X_NONE;
      cyc(rb(), (op == OP_JR || op == OP_NOP) ? stop_b : rb(), rb(), rb(), ir, x3, "t3");
      if (op == OP_BR) begin
         cyc(rb(), rb(), rb(), rb(), ir, X_B4, "b4");
         cyc(rb(), rb(), rb(), rb(), ir, X_B5, "b5");
         if (abort_b5) begin
            #1 clr = 1'b0;
            ill_m = 1'b0;
            #1;
            checks++;
            assert (obs === 23'd0) else begin
               errors++;
               $error("FAIL clr_async: observed=%h expected=%h", obs, 23'd0);
            end
            halted = 1'b1;
            return;
         end
         cyc(rb(), stop_b, rb(), con, ir, con ? X_B6T : X_NONE, "b6");
         halted = stop_b;
      end else if (op == OP_JR || op == OP_NOP) begin
         halted = stop_b;
      end else begin
         if (op != OP_HALT) ill_m = 1'b1;
         halted = 1'b1;
      end
   endtask

   localparam logic [31:0] BRMI_R6 = {OP_BR, 4'd6, 4'd3, 19'd25};
   localparam logic [31:0] JR_R3   = {OP_JR, 4'd3, 23'd0};
   localparam logic [31:0] NOP_I   = {OP_NOP, 27'd0};
   localparam logic [31:0] BAD_I   = {5'b11111, 27'd0};

   initial begin
      bit h;
      start = 1'b0; stop = 1'b0; mem_ready = 1'b0; CON_ff = 1'b0; IR_Data = 32'd0;
      clr = 1'b1;
      #2 clr = 1'b0;
      #1;
      checks++;
      assert (obs === 23'd0) else begin
         errors++;
         $error("FAIL reset: observed=%h expected=%h", obs, 23'd0);
      end
      @(negedge clk);
      clr = 1'b1;

      // start and stop together must not leave IDLE
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, X_IDLE, "start_stop_idle");
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, X_IDLE, "start_stop_idle");

      // branch not taken, then taken
      pc_reset();
      resume(1);
      do_instr(BRMI_R6, 0, 1'b0, 1'b1, 1'b0, h);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, X_IDLE, "halt_after_br");
      chk32("pc_br_not_taken", pc, 32'd1);
      pc_reset();
      resume(1);
      do_instr(BRMI_R6, 0, 1'b1, 1'b1, 1'b0, h);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, X_IDLE, "halt_after_br");
      chk32("pc_br_taken", pc, 32'h1A);

      // memory wait of three cycles in T1
      resume(1);
      do_instr(NOP_I, 3, 1'b0, 1'b0, 1'b0, h);
      do_instr(JR_R3, 0, 1'b0, 1'b1, 1'b0, h);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, X_IDLE, "halt_after_jr");
      chk32("pc_jr", pc, rf(4'd3));

      // async clear in the middle of B5, then restart
      resume(1);
      do_instr(BRMI_R6, 1, 1'b0, 1'b0, 1'b1, h);
      @(negedge clk);
      clr = 1'b1;
      resume(1);
      do_instr(NOP_I, 0, 1'b0, 1'b1, 1'b0, h);

      // unsupported opcode is sticky across restart
      resume(1);
      do_instr(BAD_I, 0, 1'b0, 1'b0, 1'b0, h);
      resume(2);
      do_instr(NOP_I, 1, 1'b0, 1'b1, 1'b0, h);
      chk32("illegal_sticky", 32'(illegal), 32'd1);

      // random instruction stream
      @(negedge clk);
      clr = 1'b0;
      ill_m = 1'b0;
      @(negedge clk);
      clr = 1'b1;
      resume(1);
      for (int i = 0; i < 60; i++) begin
         logic [31:0] r;
         logic [4:0]  op;
         int          sel;
         r = $urandom();
         sel = $urandom_range(0, 9);
         case (sel)
            0, 1, 2, 3: op = OP_BR;
            4, 5:       op = OP_JR;
            6, 7:       op = OP_NOP;
            8:          op = OP_HALT;
            default: begin
               op = 5'($urandom_range(0, 31));
               while (op == OP_BR || op == OP_JR || op == OP_NOP || op == OP_HALT)
                  op = 5'($urandom_range(0, 31));
            end
         endcase
         do_instr({op, r[26:0]}, $urandom_range(0, 3), rb(), ($urandom_range(0, 3) == 0),
                  1'b0, h);
         if (h) resume($urandom_range(1, 3));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
